// File: rtl/wallace_cpa_pipe.sv
// Two-stage carry-propagate adder that resolves the Wallace-tree sum/carry vectors.
// The low half is added in stage 1 and the high half in stage 2, with a valid/ready handshake on both sides.
module wallace_cpa_pipe #(
    parameter int DW = 16,
    parameter int TW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [DW-1:0] sum_i,
    input  logic [DW-1:0] carry_i,
    input  logic [TW-1:0] tag_i,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [DW-1:0] result_o,
    output logic          cout_o,
    output logic [TW-1:0] tag_o
);

    localparam int HALF = DW / 2;

    logic            r_s1Valid;
    logic [HALF-1:0] r_s1Lo;
    logic            r_s1Cin;
    logic [HALF-1:0] r_s1SumHi;
    logic [HALF-1:0] r_s1CarryHi;
    logic [TW-1:0]   r_s1Tag;

    logic            r_s2Valid;
    logic [DW-1:0]   r_s2Result;
    logic            r_s2Cout;
    logic [TW-1:0]   r_s2Tag;

    logic            w_s1En;
    logic            w_s2En;
    logic [HALF:0]   w_loSum;
    logic [HALF:0]   w_hiSum;

    // A stage may load when it is empty or when the stage after it is draining.
    assign w_s2En  = !r_s2Valid || ready_i;
    assign w_s1En  = !r_s1Valid || w_s2En;
    assign ready_o = w_s1En;

    assign w_loSum = {1'b0, sum_i[HALF-1:0]} + {1'b0, carry_i[HALF-1:0]};
    assign w_hiSum = {1'b0, r_s1SumHi} + {1'b0, r_s1CarryHi} + {{HALF{1'b0}}, r_s1Cin};

    // Data registers load on every enable; only the valid bits decide what is observable.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1Valid   <= 1'b0;
            r_s1Lo      <= '0;
            r_s1Cin     <= 1'b0;
            r_s1SumHi   <= '0;
            r_s1CarryHi <= '0;
            r_s1Tag     <= '0;
        end else if (w_s1En) begin
            r_s1Valid   <= valid_i;
            r_s1Lo      <= w_loSum[HALF-1:0];
            r_s1Cin     <= w_loSum[HALF];
            r_s1SumHi   <= sum_i[DW-1:HALF];
            r_s1CarryHi <= carry_i[DW-1:HALF];
            r_s1Tag     <= tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2Valid  <= 1'b0;
            r_s2Result <= '0;
            r_s2Cout   <= 1'b0;
            r_s2Tag    <= '0;
        end else if (w_s2En) begin
            r_s2Valid  <= r_s1Valid;
            r_s2Result <= {w_hiSum[HALF-1:0], r_s1Lo};
            r_s2Cout   <= w_hiSum[HALF];
            r_s2Tag    <= r_s1Tag;
        end
    end

    assign valid_o  = r_s2Valid;
    assign result_o = r_s2Result;
    assign cout_o   = r_s2Cout;
    assign tag_o    = r_s2Tag;

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
// Self-checking bench for wallace_cpa_pipe: a scoreboard queue of expected results plus per-scenario tasks.
module tb_wallace_cpa_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic        cout;
        logic [3:0]  tag;
    } exp_t;

    logic        clk;
    logic        rst_ni;
    logic        validIn;
    logic        ready_o;
    logic [15:0] sumIn;
    logic [15:0] carryIn;
    logic [3:0]  tagIn;
    logic        valid_o;
    logic        readyIn;
    logic [15:0] result_o;
    logic        cout_o;
    logic [3:0]  tag_o;

    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;
    int   cycleCount = 0;

    logic        holdPrev = 1'b0;
    logic [15:0] prevRes;
    logic        prevCout;
    logic [3:0]  prevTag;

    wallace_cpa_pipe #(.DW(16), .TW(4)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .valid_i (validIn),
        .ready_o (ready_o),
        .sum_i   (sumIn),
        .carry_i (carryIn),
        .tag_i   (tagIn),
        .valid_o (valid_o),
        .ready_i (readyIn),
        .result_o(result_o),
        .cout_o  (cout_o),
        .tag_o   (tag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount++;

    // Output-side scoreboard and stall-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_ni) begin
            holdPrev <= 1'b0;
        end else begin
            if (holdPrev) begin
                nChecks++;
                if (valid_o !== 1'b1 || result_o !== prevRes || cout_o !== prevCout || tag_o !== prevTag) begin
                    nFails++;
                    $display("[TB] FAIL stall_hold: got v=%b res=%h c=%b tag=%0d, need v=1 res=%h c=%b tag=%0d",
                             valid_o, result_o, cout_o, tag_o, prevRes, prevCout, prevTag);
                end
            end
            if (valid_o === 1'b1 && readyIn === 1'b1) begin
                nChecks++;
                if (sb.size() == 0) begin
                    nFails++;
                    $display("[TB] FAIL sb_unexpected: got res=%h tag=%0d, need no output", result_o, tag_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (result_o !== e.res || cout_o !== e.cout || tag_o !== e.tag) begin
                        nFails++;
                        $display("[TB] FAIL sb_result: got res=%h c=%b tag=%0d, need res=%h c=%b tag=%0d",
                                 result_o, cout_o, tag_o, e.res, e.cout, e.tag);
                    end
                end
            end
            holdPrev <= (valid_o === 1'b1 && readyIn === 1'b0);
            prevRes  <= result_o;
            prevCout <= cout_o;
            prevTag  <= tag_o;
        end
    end

    function automatic exp_t model(input logic [15:0] s, input logic [15:0] c, input logic [3:0] t);
        logic [16:0] full;
        full = {1'b0, s} + {1'b0, c};
        model.res  = full[15:0];
        model.cout = full[16];
        model.tag  = t;
    endfunction

    task automatic waitDrive();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand, holds it until accepted (bounded) and records the expected result.
    task automatic sendOp(input logic [15:0] s, input logic [15:0] c, input logic [3:0] t);
        int waited = 0;
        validIn = 1'b1;
        sumIn   = s;
        carryIn = c;
        tagIn   = t;
        @(negedge clk);
        while (ready_o !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        nChecks++;
        if (ready_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL accept_timeout: got ready_o=%b, need 1", ready_o);
        end else begin
            sb.push_back(model(s, c, t));
        end
        waitDrive();
        validIn = 1'b0;
    endtask

    task automatic drainQueue(input string name);
        int waited = 0;
        readyIn = 1'b1;
        while (sb.size() > 0 && waited < 20) begin
            waitDrive();
            waited++;
        end
        @(negedge clk);
        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("[TB] FAIL %s_drain: got %0d results pending, need 0", name, sb.size());
        end
        waitDrive();
    endtask

    task automatic test_reset();
        rst_ni  = 1'b1;
        validIn = 1'b0;
        readyIn = 1'b1;
        sumIn   = '0;
        carryIn = '0;
        tagIn   = '0;
        #1 rst_ni = 1'b0;
        #2;
        nChecks++;
        if (valid_o !== 1'b0 || result_o !== 16'h0 || cout_o !== 1'b0 || tag_o !== 4'h0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got v=%b res=%h c=%b tag=%0d, need all 0", valid_o, result_o, cout_o, tag_o);
        end
        repeat (2) @(negedge clk);
        #2 rst_ni = 1'b1;
        waitDrive();
        nChecks++;
        if (ready_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL reset_ready: got %b, need 1", ready_o);
        end
    endtask

    task automatic test_directed();
        logic [15:0] sv [4];
        logic [15:0] cv [4];
        logic [15:0] rv [4];
        logic        co [4];
        sv = '{16'h00FF, 16'hFFFF, 16'h8000, 16'h1234};
        cv = '{16'h0001, 16'h0001, 16'h8000, 16'h0000};
        rv = '{16'h0100, 16'h0000, 16'h0000, 16'h1234};
        co = '{1'b0, 1'b1, 1'b1, 1'b0};
        readyIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sendOp(sv[i], cv[i], 4'(i + 3));
            @(negedge clk);
            nChecks++;
            if (valid_o !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL directed_latency%0d: got valid_o=%b one cycle after accept, need 0", i, valid_o);
            end
            @(negedge clk);
            nChecks++;
            if (valid_o !== 1'b1 || result_o !== rv[i] || cout_o !== co[i] || tag_o !== 4'(i + 3)) begin
                nFails++;
                $display("[TB] FAIL directed%0d: got v=%b res=%h c=%b tag=%0d, need v=1 res=%h c=%b tag=%0d",
                         i, valid_o, result_o, cout_o, tag_o, rv[i], co[i], i + 3);
            end
            waitDrive();
        end
        drainQueue("directed");
    endtask

    task automatic test_backpressure();
        logic [3:0] needTag [3];
        needTag = '{4'd1, 4'd2, 4'd3};
        readyIn = 1'b0;
        sendOp(16'h0101, 16'h0010, 4'd1);
        sendOp(16'h0202, 16'h0020, 4'd2);
        validIn = 1'b1;
        sumIn   = 16'h0303;
        carryIn = 16'h0030;
        tagIn   = 4'd3;
        repeat (3) begin
            @(negedge clk);
            nChecks++;
            if (ready_o !== 1'b0 || valid_o !== 1'b1 || tag_o !== 4'd1) begin
                nFails++;
                $display("[TB] FAIL bp_full: got ready_o=%b v=%b tag=%0d, need ready_o=0 v=1 tag=1", ready_o, valid_o, tag_o);
            end
            waitDrive();
        end
        readyIn = 1'b1;
        @(negedge clk);
        nChecks++;
        if (ready_o !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL bp_release_ready: got %b, need 1", ready_o);
        end else begin
            sb.push_back(model(16'h0303, 16'h0030, 4'd3));
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            nChecks++;
            if (valid_o !== 1'b1 || tag_o !== needTag[i]) begin
                nFails++;
                $display("[TB] FAIL bp_order%0d: got v=%b tag=%0d, need v=1 tag=%0d", i, valid_o, tag_o, needTag[i]);
            end
            waitDrive();
            validIn = 1'b0;
        end
        drainQueue("backpressure");
    endtask

    task automatic test_throughput();
        int startCycle;
        readyIn = 1'b1;
        startCycle = cycleCount;
        for (int i = 0; i < 100; i++) begin
            sendOp(16'($urandom), 16'($urandom), 4'($urandom));
        end
        nChecks++;
        if (cycleCount - startCycle != 100) begin
            nFails++;
            $display("[TB] FAIL throughput_cycles: got %0d cycles, need 100", cycleCount - startCycle);
        end
        drainQueue("throughput");
    endtask

    task automatic test_reset_midflight();
        readyIn = 1'b0;
        sendOp(16'h1111, 16'h2222, 4'd5);
        sendOp(16'h4444, 16'h1111, 4'd6);
        #3 rst_ni = 1'b0;
        #1;
        nChecks++;
        if (valid_o !== 1'b0 || result_o !== 16'h0 || tag_o !== 4'h0) begin
            nFails++;
            $display("[TB] FAIL midreset_clear: got v=%b res=%h tag=%0d, need all 0", valid_o, result_o, tag_o);
        end
        sb.delete();
        @(negedge clk);
        #2 rst_ni = 1'b1;
        waitDrive();
        readyIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++;
            if (valid_o !== 1'b0) begin
                nFails++;
                $display("[TB] FAIL midreset_ghost%0d: got valid_o=%b, need 0", i, valid_o);
            end
        end
        waitDrive();
        sendOp(16'h0F0F, 16'h0101, 4'd7);
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midreset_early: got valid_o=%b, need 0", valid_o);
        end
        @(negedge clk);
        nChecks++;
        if (valid_o !== 1'b1 || result_o !== 16'h1010 || tag_o !== 4'd7) begin
            nFails++;
            $display("[TB] FAIL midreset_new: got v=%b res=%h tag=%0d, need v=1 res=1010 tag=7", valid_o, result_o, tag_o);
        end
        waitDrive();
        drainQueue("midreset");
    endtask

    // ready_i toggles every cycle; an offer that is not taken stays stable until it is.
    task automatic test_toggle();
        logic pending = 1'b0;
        readyIn = 1'b0;
        for (int i = 0; i < 200; i++) begin
            readyIn = ~readyIn;
            if (!pending) begin
                validIn = 1'($urandom_range(0, 1));
                sumIn   = 16'($urandom);
                carryIn = 16'($urandom);
                tagIn   = 4'($urandom);
            end
            @(negedge clk);
            if (validIn && ready_o === 1'b1) begin
                sb.push_back(model(sumIn, carryIn, tagIn));
                pending = 1'b0;
            end else begin
                pending = validIn;
            end
            waitDrive();
        end
        validIn = 1'b0;
        drainQueue("toggle");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_throughput();
        test_reset_midflight();
        test_toggle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/wallace_cpa_pipe.md
Name: wallace_cpa_pipe

Overview:
- Two-stage pipelined carry-propagate adder that sits directly downstream of the multiplier's Wallace-tree compressor.
- Takes the tree's redundant sum/carry vectors and resolves them into a single DW-bit product: low half in stage 1, high half in stage 2.
- Valid/ready handshake on both sides so the multiplier datapath can be stalled by its consumer without losing or duplicating results.

Parameters:
- DW, 16, width of the sum/carry vectors and of the result; must be even and >= 2; HALF = DW/2.
- TW, 4, width of the sideband tag carried alongside each operation, unmodified.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  upstream offers sum_i/carry_i/tag_i this cycle.
- ready_o  output  1  block accepts the offered operand this cycle.
- sum_i  input  DW  partial-sum vector from the compressor tree.
- carry_i  input  DW  carry vector from the compressor tree, already aligned (shifted) by the tree.
- tag_i  input  TW  sideband tag.
- valid_o  output  1  result_o/cout_o/tag_o hold a valid result.
- ready_i  input  1  downstream accepts the result this cycle.
- result_o  output  DW  (sum_i + carry_i) mod 2^DW.
- cout_o  output  1  carry out of bit DW-1 (informational; the multiplier discards it).
- tag_o  output  TW  tag that entered with this operand.

Behaviour:
- Clock and reset are clk_i and rst_ni; rst_ni is asynchronous and active-low.
- Reset: all registers clear immediately on rst_ni low, including stage valids. valid_o=0, result_o=0, cout_o=0, tag_o=0. ready_o=1 once rst_ni is high.
- Stage 1 register (s1) captures per accepted operand:
  - {c_lo, r_lo} = sum_i[HALF-1:0] + carry_i[HALF-1:0], HALF+1 bits.
  - sum_i[DW-1:HALF], carry_i[DW-1:HALF] and tag_i, unmodified.
- Stage 2 register (s2, drives outputs):
  - {cout_o, r_hi} = s1 upper sum + s1 upper carry + c_lo.
  - result_o = {r_hi, r_lo}.
- All arithmetic is unsigned, modulo 2^DW. No saturation.
- Handshake (standard pipeline, no bubbles required to advance):
  - s2_en = !s2_valid | ready_i.
  - s1_en = !s1_valid | s2_en.
  - ready_o = s1_en, purely combinational from state and ready_i.
- Transfers:
  - Input transfer on valid_i & ready_o. Output transfer on valid_o & ready_i.
  - s1 loads when s1_en: s1_valid <= valid_i.
  - s2 loads when s2_en: s2_valid <= s1_valid.
- Latency 2 cycles from input transfer to valid_o when ready_i is held high. Throughput 1 operation per cycle.
- Stall: while valid_o=1 and ready_i=0, result_o/cout_o/tag_o/valid_o hold stable. At most 2 operations in flight; with both stages full, ready_o=0.
- Simultaneous output transfer and input transfer in the same cycle with both stages full: both stages advance; no loss, no duplicate, order preserved.
- Upstream must hold its data stable while valid_i=1 and ready_o=0. Data inputs are ignored when valid_i=0.
- Data registers may load on any enable; only valid bits gate observability. Reset still clears everything.
- Reset asserted mid-operation: in-flight operations are discarded; no valid_o pulse after rst_ni rises until new input is accepted.

Test Plan:
- DW=16, ready_i=1. sum_i=0x00FF, carry_i=0x0001, tag_i=3 -> 2 cycles later valid_o=1, result_o=0x0100, cout_o=0, tag_o=3 (carry crosses the half boundary).
- sum_i=0xFFFF, carry_i=0x0001 -> result_o=0x0000, cout_o=1. sum_i=0x8000, carry_i=0x8000 -> result_o=0x0000, cout_o=1. sum_i=0x1234, carry_i=0x0000 -> result_o=0x1234, cout_o=0.
- Backpressure: ready_i=0 while 3 back-to-back operands (tags 1,2,3) are offered -> tags 1,2 accepted, ready_o=0 on the third. Outputs hold tag 1 stable. Release ready_i -> tags 1,2,3 emerge on consecutive cycles in order, each exactly once.
- Full pipe, steady ready_i=1 with continuous valid_i: 100 random operands -> one result per cycle, each result_o == (sum_i+carry_i) mod 2^16 with matching tag and cout_o.
- Reset mid-flight: 2 operands in flight, pulse rst_ni low asynchronously (mid-cycle) -> valid_o=0 and result_o=0 immediately. After release, no result until a new operand is accepted; that operand appears 2 cycles after acceptance.
- ready_i toggling every cycle with random valid_i -> scoreboard shows no loss or duplication, and outputs stay stable whenever valid_o=1 and ready_i=0.
